// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  ready, diff, bout, ovf, done
  );

  modport slave (
    input  start, a, b, bin,
    output ready, diff, bout, ovf, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor computing a - b - bin
// with registered difference, borrow-out and two's-complement overflow.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic a_i;
  logic b_i;
  logic d_i;
  logic br_nxt;
  logic last;

  assign a_i    = a_sr[0];
  assign b_i    = b_sr[0];
  assign d_i    = a_i ^ b_i ^ br;
  assign br_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == IDLE);
    bus.done  = (state == DONE);
  end

  // On the last bit the operand shifters hold the original MSBs, so the
  // overflow flag can be formed from the same bit slice as the final borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      d_sr <= '0;
      cnt  <= '0;
      br   <= bus.bin;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= {d_i, d_sr[WIDTH-1:1]};
      br   <= br_nxt;
      cnt  <= last ? '0 : cnt + 1'b1;
      if (last) begin
        diff_q <= {d_i, d_sr[WIDTH-1:1]};
        bout_q <= br_nxt;
        ovf_q  <= (a_i ^ b_i) & (d_i ^ a_i);
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  time  t_first;
  time  t_second;

  serial_subtractor_if #(.WIDTH(4)) bus ();

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts an operation at a negedge and returns at the negedge where done is seen.
  task automatic do_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                       input logic tbin, input logic [3:0] ed, input logic eb,
                       input logic eo, input bit disturb, output time t_done);
    int         cyc;
    int         n_done;
    logic [3:0] held;
    @(negedge clk);
    check({tag, "_ready_at_start"}, 32'(bus.ready), 32'd1);
    held      = bus.diff;
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.bin   = tbin;
    cyc       = 0;
    t_done    = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (disturb && cyc == 2) begin
        bus.start = 1'b1;
        bus.a     = ~ta;
        bus.b     = ~tb_v;
        bus.bin   = ~tbin;
      end
      if (!bus.done) begin
        check({tag, "_ready_low_run"}, 32'(bus.ready), 32'd0);
        check({tag, "_diff_held_run"}, 32'(bus.diff), 32'(held));
      end
    end while (!bus.done && cyc < 20);
    t_done = $time;
    check({tag, "_done_cycle"}, 32'(cyc), 32'd5);
    check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
    check({tag, "_bout"}, 32'(bus.bout), 32'(eb));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    check({tag, "_ready_in_done"}, 32'(bus.ready), 32'd0);
    if (disturb) begin
      n_done = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.done) n_done++;
      end
      check({tag, "_extra_done"}, 32'(n_done), 32'd0);
      check({tag, "_diff_kept"}, 32'(bus.diff), 32'(ed));
    end
  endtask

  initial begin
    int n_done;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;

    do_op("sub5_3", 4'd5, 4'd3, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, t_first);
    @(negedge clk);
    check("sub5_3_ready_after", 32'(bus.ready), 32'd1);
    check("sub5_3_done_low_after", 32'(bus.done), 32'd0);

    do_op("sub3_9", 4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0, t_first);
    do_op("sub0_0_b", 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, t_first);
    do_op("sub7_8_dist", 4'h7, 4'h8, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, t_first);

    // abort in the second RUN cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'h9;
    bus.b     = 4'h2;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_bout", 32'(bus.bout), 32'd0);
    check("abort_ovf", 32'(bus.ovf), 32'd0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    do_op("after_abort", 4'd5, 4'd3, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, t_first);

    do_op("b2b_6_1", 4'd6, 4'd1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, t_first);
    do_op("b2b_1_6", 4'd1, 4'd6, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, t_second);
    check("b2b_spacing", 32'((t_second - t_first) / 10), 32'd6);

    @(negedge clk);
    check("final_ready", 32'(bus.ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL default to 4 and set the operand and result bit width (legal range 2..16).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset; asserting it SHALL immediately force reset state, and deassertion SHALL be used synchronously to clk.
REQ-004 start  input  1  SHALL request a subtraction; it is sampled only when ready=1.
REQ-005 a  input  WIDTH  SHALL carry the minuend, captured with start.
REQ-006 b  input  WIDTH  SHALL carry the subtrahend, captured with start.
REQ-007 bin  input  1  SHALL carry the borrow-in, captured with start.
REQ-008 ready  output  1  SHALL be high when the block is idle and able to accept start.
REQ-009 diff  output  WIDTH  SHALL carry the registered result a - b - bin, modulo 2^WIDTH.
REQ-010 bout  output  1  SHALL carry the registered final borrow-out (1 when the unsigned a < b + bin).
REQ-011 ovf  output  1  SHALL carry the registered two's-complement overflow flag.
REQ-012 done  output  1  SHALL pulse high for exactly one cycle when diff/bout/ovf are updated.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, and no others; unused encodings SHALL return to IDLE.
REQ-014 In IDLE, ready SHALL be 1; start=1 SHALL latch a, b and bin into internal shift registers, clear the bit counter, load the borrow flop with bin and go to RUN.
REQ-015 In IDLE with start=0, the state and outputs SHALL hold.
REQ-016 In RUN, one bit per cycle SHALL be processed, LSB first: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-017 The bit counter SHALL wrap from WIDTH-1 to 0; after bit WIDTH-1 is processed the FSM SHALL go to DONE.
REQ-018 On entry to DONE, diff SHALL load the assembled result, bout SHALL load the final borrow, and ovf SHALL load (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
REQ-019 done SHALL be 1 only while in DONE; DONE SHALL return to IDLE unconditionally after one cycle.
REQ-020 Latency: with start high in cycle 0 (ready=1), done SHALL be high in cycle WIDTH+1 and ready SHALL be high again in cycle WIDTH+2.
REQ-021 ready SHALL be 0 in RUN and DONE; start asserted in those states SHALL be ignored, with no effect on state or latched operands.
REQ-022 Changes to a, b and bin after capture SHALL NOT affect the result in progress.
REQ-023 diff, bout and ovf SHALL hold their last values until the next DONE entry and SHALL NOT change during RUN.
REQ-024 Back-to-back operation SHALL be allowed: start in the first cycle that ready=1 after a done SHALL be accepted.

Reset
REQ-025 On rst_n=0 the FSM SHALL enter IDLE, and the counter, borrow flop and shift registers SHALL clear; outputs SHALL be ready=1, done=0, diff=0, bout=0 and ovf=0.
REQ-026 A reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after reset release SHALL complete normally.

Verification (WIDTH=4)
REQ-027 a=5, b=3, bin=0 -> done in cycle 5 with diff=4'h2, bout=0, ovf=0; ready=1 in cycle 6.
REQ-028 a=4'h3, b=4'h9, bin=0 -> diff=4'hA, bout=1, ovf=1.
REQ-029 a=0, b=0, bin=1 -> diff=4'hF, bout=1, ovf=0.
REQ-030 a=7, b=8 -> diff=4'hF, bout=1, ovf=1; start pulsed and a/b changed during RUN -> ignored, the result is unchanged, and exactly one done pulse occurs.
REQ-031 rst_n low in cycle 2 of RUN -> no done pulse, outputs return to the reset values, ready=1; then a=5, b=3 -> diff=4'h2.
REQ-032 Two back-to-back starts (6-1 and then 1-6) -> two done pulses 6 cycles apart: diff=4'h5, bout=0, then diff=4'hB, bout=1.
